line_window_buffer: RTL and testbench
=====================================

Name: line_window_buffer

Overview:
- Parametrised multi-line buffer for the Sobel datapath. Generalises the single FIFO line buffer to NUM_LINES vertically aligned taps of DATA_W bits over an image row of LINE_W pixels.
- Each accepted pixel produces one registered column of NUM_LINES samples: current row plus the same column from the previous NUM_LINES-1 rows. This column feeds the 3x3 window/kernel stage.
- Adds stall-safe advance (only on we_i), frame restart, end-of-line marking and an optional zero-padding mode.

Parameters:
- DATA_W, 8, pixel width in bits
- LINE_W, 640, pixels per image row (delay-line depth), >= 2
- NUM_LINES, 3, taps per output column (NUM_LINES-1 stored rows), >= 2
- ZERO_FILL, 0, 1 = unfilled rows read as 0 and output valid from first row; 0 = output valid only once all taps hold real rows

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset (rst==0 resets)
- we_i  input  1  pixel valid; pipeline advances only when high
- sof_i  input  1  start of frame, qualified by we_i; marks data_i as row 0, column 0
- data_i  input  DATA_W  incoming pixel
- taps_o  output  NUM_LINES*DATA_W  tap k at bits [k*DATA_W +: DATA_W]; k=0 current row, k=NUM_LINES-1 oldest row
- valid_o  output  1  taps_o holds a valid column
- eol_o  output  1  high with the valid_o column that is the last column (LINE_W-1) of a row
- col_o  output  clog2(LINE_W)  column index of the column on taps_o

Behaviour:
- Reset (rst==0 at edge): write pointer, column counter and fill counter go to 0. taps_o=0, valid_o=0, eol_o=0, col_o=0. Line memories are not cleared. Reset mid-row discards partial row state; the next we_i pixel is column 0, row 0.
- Storage: NUM_LINES-1 memories of LINE_W x DATA_W share one write pointer ptr.
  - On we_i: read-before-write at ptr. mem0[ptr]<=data_i; mem[j][ptr]<=old mem[j-1][ptr].
  - ptr wraps LINE_W-1 -> 0.
- Output register updates only on we_i; latency 1 cycle from data_i to taps_o.
  - tap0=data_i
  - tap k = old mem[k-1][ptr]
  - col_o = column counter value before increment
  - eol_o = (col == LINE_W-1)
- we_i low: ptr, counters, memories and all outputs hold. valid_o is forced low in that cycle (one valid_o pulse per accepted pixel).
- Fill counter fill: counts completed rows and saturates at NUM_LINES-1. It increments when col wraps.
  - ZERO_FILL=0: valid_o = we_i of previous cycle AND fill==NUM_LINES-1 at that pixel.
  - ZERO_FILL=1: valid_o = we_i of previous cycle. Tap k is forced to 0 while fill<k.
- sof_i with we_i:
  - ptr, col and fill treated as 0 for this pixel; the pixel is written at address 0.
  - Next state: ptr=1, col=1, fill=0.
  - Memory contents are not cleared; the ZERO_FILL/valid gating hides stale rows.
  - sof_i without we_i is ignored.
- LINE_W=1 is unsupported. Counter widths are clog2(LINE_W), minimum 1.

Test Plan:
- LINE_W=4, NUM_LINES=3, ZERO_FILL=0; rst=0 for 2 cycles, then 12 consecutive we_i pixels value row*16+col starting with sof_i -> valid_o low for first 8 outputs. First valid column, after pixel 0x20, is taps_o={0x00,0x10,0x20} (tap2,tap1,tap0), col_o=0. After 0x23: eol_o=1, col_o=3.
- Same config, we_i deasserted for 3 cycles between pixels 0x21 and 0x22 -> outputs hold {0x01,0x11,0x21}, valid_o=0 during stall. Next column is {0x02,0x12,0x22}, valid_o=1.
- ZERO_FILL=1, pixel 0x00 with sof_i -> next cycle valid_o=1, taps_o={0,0,0x00}. Pixel 0x11 -> {0,0x01,0x11}.
- Mid-frame sof_i on pixel value 0xAA at ptr=2 -> output col_o=0, valid_o=0 (ZERO_FILL=0). Next 7 pixels produce no valid_o. Valid_o resumes on the 9th pixel after the sof_i.
- rst=0 asserted during row 1 col 2 -> next cycle all outputs 0. First pixel after release is column 0, fill 0, no valid_o until two full rows are rewritten.
- DATA_W=12, NUM_LINES=5, LINE_W=3; 15 pixels of 12'hFFF-ramp -> first valid_o after pixel 13. tap4 equals pixel 1, bits [59:48] correctly placed.

Source files
------------

// File: rtl/line_window_if.sv
// Pixel-in / column-out bundle for line_window_buffer.
// The source drives pixels and the buffer returns one column of vertical taps per accepted pixel.
interface line_window_if #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LINE_W    = 640,
    parameter int unsigned NUM_LINES = 3
) ();
    localparam int unsigned ColW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

    logic                          we_i;
    logic                          sof_i;
    logic [DATA_W-1:0]             data_i;
    logic [NUM_LINES*DATA_W-1:0]   taps_o;
    logic                          valid_o;
    logic                          eol_o;
    logic [ColW-1:0]               col_o;

    modport master (
        output we_i, sof_i, data_i,
        input  taps_o, valid_o, eol_o, col_o
    );

    modport slave (
        input  we_i, sof_i, data_i,
        output taps_o, valid_o, eol_o, col_o
    );
endinterface

// File: rtl/line_window_buffer.sv
// Multi-row delay-line buffer: each accepted pixel emits a registered column of NUM_LINES
// vertically aligned samples (current row first, oldest row last).
module line_window_buffer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LINE_W    = 640,
    parameter int unsigned NUM_LINES = 3,
    parameter int unsigned ZERO_FILL = 0
) (
    input logic          clk,
    input logic          rst,
    line_window_if.slave bus
);
    localparam int unsigned ColW  = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int unsigned FillW = $clog2(NUM_LINES);
    localparam int unsigned Rows  = NUM_LINES - 1;

    logic [DATA_W-1:0] mem [Rows][LINE_W];

    // Write pointer and column counter advance in lockstep, so one register serves both.
    logic [ColW-1:0]               ptr_q, ptr_eff, ptr_nxt;
    logic [FillW-1:0]              fill_q, fill_eff, fill_nxt;
    logic                          last_col;
    logic [NUM_LINES*DATA_W-1:0]   taps_q, taps_d;
    logic                          valid_q, eol_q;
    logic [ColW-1:0]               col_q;

    always_comb begin
        ptr_eff  = bus.sof_i ? '0 : ptr_q;
        fill_eff = bus.sof_i ? '0 : fill_q;
        last_col = (ptr_eff == ColW'(LINE_W - 1));
        ptr_nxt  = last_col ? '0 : ptr_eff + 1'b1;
        fill_nxt = (last_col && (fill_eff != FillW'(Rows))) ? fill_eff + 1'b1 : fill_eff;

        taps_d = '0;
        taps_d[DATA_W-1:0] = bus.data_i;
        // With zero fill, taps reaching into rows not yet written this frame read as 0.
        for (int k = 1; k < NUM_LINES; k++) begin
            if ((ZERO_FILL == 0) || (int'(fill_eff) >= k)) begin
                taps_d[k*DATA_W +: DATA_W] = mem[k-1][ptr_eff];
            end
        end
    end

    // Read-before-write shift: every stored row moves one line older at this column.
    always_ff @(posedge clk) begin
        if (rst && bus.we_i) begin
            mem[0][ptr_eff] <= bus.data_i;
            for (int j = 1; j < Rows; j++) begin
                mem[j][ptr_eff] <= mem[j-1][ptr_eff];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q   <= '0;
            fill_q  <= '0;
            taps_q  <= '0;
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
            col_q   <= '0;
        end else if (bus.we_i) begin
            ptr_q   <= ptr_nxt;
            fill_q  <= fill_nxt;
            taps_q  <= taps_d;
            col_q   <= ptr_eff;
            eol_q   <= last_col;
            valid_q <= (ZERO_FILL != 0) || (fill_eff == FillW'(Rows));
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.taps_o  = taps_q;
    assign bus.valid_o = valid_q;
    assign bus.eol_o   = eol_q;
    assign bus.col_o   = col_q;
endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer across three configurations.
module tb_line_window_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    line_window_if #(.DATA_W(8),  .LINE_W(4), .NUM_LINES(3)) if_a ();
    line_window_if #(.DATA_W(8),  .LINE_W(4), .NUM_LINES(3)) if_b ();
    line_window_if #(.DATA_W(12), .LINE_W(3), .NUM_LINES(5)) if_c ();

    line_window_buffer #(.DATA_W(8), .LINE_W(4), .NUM_LINES(3), .ZERO_FILL(0)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );
    line_window_buffer #(.DATA_W(8), .LINE_W(4), .NUM_LINES(3), .ZERO_FILL(1)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );
    line_window_buffer #(.DATA_W(12), .LINE_W(3), .NUM_LINES(5), .ZERO_FILL(0)) u_c (
        .clk (clk),
        .rst (rst),
        .bus (if_c)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] d, input logic s);
        @(negedge clk);
        if_a.we_i = 1'b1; if_a.sof_i = s; if_a.data_i = d;
        @(posedge clk); #1;
    endtask

    task automatic idle_a();
        @(negedge clk);
        if_a.we_i = 1'b0; if_a.sof_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push_b(input logic [7:0] d, input logic s);
        @(negedge clk);
        if_b.we_i = 1'b1; if_b.sof_i = s; if_b.data_i = d;
        @(posedge clk); #1;
    endtask

    task automatic push_c(input logic [11:0] d, input logic s);
        @(negedge clk);
        if_c.we_i = 1'b1; if_c.sof_i = s; if_c.data_i = d;
        @(posedge clk); #1;
    endtask

    task automatic quiet_all();
        @(negedge clk);
        if_a.we_i = 1'b0; if_a.sof_i = 1'b0;
        if_b.we_i = 1'b0; if_b.sof_i = 1'b0;
        if_c.we_i = 1'b0; if_c.sof_i = 1'b0;
    endtask

    task automatic pulse_reset();
        quiet_all();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0]  p8;
        logic [11:0] p12;
        logic [59:0] exp_c;

        if_a.we_i = 1'b0; if_a.sof_i = 1'b0; if_a.data_i = '0;
        if_b.we_i = 1'b0; if_b.sof_i = 1'b0; if_b.data_i = '0;
        if_c.we_i = 1'b0; if_c.sof_i = 1'b0; if_c.data_i = '0;

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_taps",  64'(if_a.taps_o),  64'h0);
        check("rst_valid", 64'(if_a.valid_o), 64'h0);
        check("rst_eol",   64'(if_a.eol_o),   64'h0);
        check("rst_col",   64'(if_a.col_o),   64'h0);
        @(negedge clk);
        rst = 1'b1;

        // 12-pixel frame, value row*16+col
        for (int i = 0; i < 12; i++) begin
            p8 = 8'(((i / 4) * 16) + (i % 4));
            push_a(p8, (i == 0));
            if (i < 8) check("fill_valid_low", 64'(if_a.valid_o), 64'h0);
            if (i == 8) begin
                check("first_taps",  64'(if_a.taps_o),  64'h001020);
                check("first_valid", 64'(if_a.valid_o), 64'h1);
                check("first_col",   64'(if_a.col_o),   64'h0);
            end
            if (i == 10) check("mid_eol", 64'(if_a.eol_o), 64'h0);
            if (i == 11) begin
                check("eol_flag",  64'(if_a.eol_o),  64'h1);
                check("eol_col",   64'(if_a.col_o),  64'h3);
                check("eol_taps",  64'(if_a.taps_o), 64'h031323);
                check("eol_valid", 64'(if_a.valid_o), 64'h1);
            end
        end

        // New frame with a 3-cycle stall between 0x21 and 0x22
        for (int i = 0; i < 10; i++) begin
            p8 = 8'(((i / 4) * 16) + (i % 4));
            push_a(p8, (i == 0));
        end
        check("pre_stall_taps",  64'(if_a.taps_o),  64'h011121);
        check("pre_stall_valid", 64'(if_a.valid_o), 64'h1);
        for (int i = 0; i < 3; i++) begin
            idle_a();
            check("stall_taps",  64'(if_a.taps_o),  64'h011121);
            check("stall_valid", 64'(if_a.valid_o), 64'h0);
        end
        push_a(8'h22, 1'b0);
        check("post_stall_taps",  64'(if_a.taps_o),  64'h021222);
        check("post_stall_valid", 64'(if_a.valid_o), 64'h1);
        push_a(8'h23, 1'b0);

        // Mid-frame restart at ptr=2
        push_a(8'h30, 1'b0);
        push_a(8'h31, 1'b0);
        push_a(8'hAA, 1'b1);
        check("msof_col",   64'(if_a.col_o),   64'h0);
        check("msof_valid", 64'(if_a.valid_o), 64'h0);
        for (int i = 1; i < 8; i++) begin
            push_a(8'(8'h40 + i), 1'b0);
            check("msof_fill_valid", 64'(if_a.valid_o), 64'h0);
        end
        push_a(8'h55, 1'b0);
        check("msof_resume_valid", 64'(if_a.valid_o), 64'h1);
        check("msof_resume_col",   64'(if_a.col_o),   64'h0);
        check("msof_resume_taps",  64'(if_a.taps_o),  64'hAA4455);

        // Reset during row 1 col 2
        for (int i = 0; i < 6; i++) begin
            p8 = 8'(((i / 4) * 16) + (i % 4));
            push_a(p8, (i == 0));
        end
        @(negedge clk);
        rst = 1'b0;
        if_a.we_i = 1'b1; if_a.sof_i = 1'b0; if_a.data_i = 8'h12;
        @(posedge clk); #1;
        check("mrst_taps",  64'(if_a.taps_o),  64'h0);
        check("mrst_valid", 64'(if_a.valid_o), 64'h0);
        check("mrst_eol",   64'(if_a.eol_o),   64'h0);
        check("mrst_col",   64'(if_a.col_o),   64'h0);
        @(negedge clk);
        rst = 1'b1;
        if_a.we_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_a(8'(8'h60 + i), 1'b0);
            if (i == 0) check("mrst_first_col", 64'(if_a.col_o), 64'h0);
            check("mrst_fill_valid", 64'(if_a.valid_o), 64'h0);
        end
        push_a(8'h68, 1'b0);
        check("mrst_resume_valid", 64'(if_a.valid_o), 64'h1);
        check("mrst_resume_col",   64'(if_a.col_o),   64'h0);
        check("mrst_resume_taps",  64'(if_a.taps_o),  64'h606468);

        // Zero-fill configuration
        pulse_reset();
        push_b(8'h00, 1'b1);
        check("zf_first_valid", 64'(if_b.valid_o), 64'h1);
        check("zf_first_taps",  64'(if_b.taps_o),  64'h000000);
        push_b(8'h01, 1'b0);
        push_b(8'h02, 1'b0);
        push_b(8'h03, 1'b0);
        check("zf_row0_eol", 64'(if_b.eol_o), 64'h1);
        push_b(8'h10, 1'b0);
        push_b(8'h11, 1'b0);
        check("zf_row1_taps",  64'(if_b.taps_o),  64'h000111);
        check("zf_row1_valid", 64'(if_b.valid_o), 64'h1);
        push_b(8'h12, 1'b0);
        push_b(8'h13, 1'b0);
        push_b(8'h20, 1'b0);
        check("zf_row2_taps", 64'(if_b.taps_o), 64'h001020);

        // Wide/deep configuration: DATA_W=12, NUM_LINES=5, LINE_W=3
        pulse_reset();
        exp_c = 60'hFFF_FFC_FF9_FF6_FF3;
        for (int i = 0; i < 15; i++) begin
            p12 = 12'(12'hFFF - i);
            push_c(p12, (i == 0));
            if (i < 12) check("c_fill_valid", 64'(if_c.valid_o), 64'h0);
            if (i == 12) begin
                check("c_first_valid", 64'(if_c.valid_o), 64'h1);
                check("c_first_taps",  64'(if_c.taps_o),  64'(exp_c));
                check("c_tap4_field",  64'(if_c.taps_o[59:48]), 64'hFFF);
            end
            if (i == 14) begin
                check("c_eol", 64'(if_c.eol_o), 64'h1);
                check("c_col", 64'(if_c.col_o), 64'h2);
            end
        end
        quiet_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
